// File: rtl/nn_frame_loader.sv
// Serial-to-parallel frame loader for the speech network: gathers IN_SIZE feature words,
// holds the vector while the network settles, captures the class and hands it downstream.
module nn_frame_loader #(
   parameter int IN_SIZE    = 16,
   parameter int DATA_W     = 16,
   parameter int CLASS_W    = 2,
   parameter int NN_LATENCY = 6
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [DATA_W-1:0]               s_data,
   input  logic                            s_valid,
   input  logic                            s_last,
   output logic                            s_ready,
   output logic [IN_SIZE-1:0][DATA_W-1:0]  frame_vector,
   output logic                            frame_valid,
   input  logic [CLASS_W-1:0]              nn_class,
   output logic [CLASS_W-1:0]              m_class,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic                            frame_err
);

   localparam int IDX_W = $clog2(IN_SIZE);
   localparam int CNT_W = $clog2(NN_LATENCY + 1);

   typedef enum logic [1:0] {
      ST_FILL,
      ST_WAIT,
      ST_OUT
   } state_t;

   state_t                           state_q, state_d;
   logic [IDX_W-1:0]                 wr_idx_q, wr_idx_d;
   logic [CNT_W-1:0]                 lat_cnt_q, lat_cnt_d;
   logic [IN_SIZE-1:0][DATA_W-1:0]   frame_vector_q, frame_vector_d;
   logic                             s_ready_q, s_ready_d;
   logic                             frame_valid_q, frame_valid_d;
   logic                             m_valid_q, m_valid_d;
   logic [CLASS_W-1:0]               m_class_q, m_class_d;
   logic                             frame_err_q, frame_err_d;
   logic                             accept;
   logic                             last_slot;

   assign accept    = s_valid & s_ready_q;
   assign last_slot = (wr_idx_q == IDX_W'(IN_SIZE - 1));

   always_comb begin
      state_d        = state_q;
      wr_idx_d       = wr_idx_q;
      lat_cnt_d      = lat_cnt_q;
      frame_vector_d = frame_vector_q;
      frame_valid_d  = frame_valid_q;
      m_valid_d      = m_valid_q;
      m_class_d      = m_class_q;
      frame_err_d    = 1'b0;

      case (state_q)
         ST_FILL: begin
            if (accept) begin
               if (s_last && last_slot) begin
                  frame_vector_d[wr_idx_q] = s_data;
                  wr_idx_d      = '0;
                  lat_cnt_d     = CNT_W'(NN_LATENCY);
                  frame_valid_d = 1'b1;
                  state_d       = ST_WAIT;
               end else if (s_last || last_slot) begin
                  // Malformed frame: stale words stay behind and get overwritten by the next frame
                  wr_idx_d    = '0;
                  frame_err_d = 1'b1;
               end else begin
                  frame_vector_d[wr_idx_q] = s_data;
                  wr_idx_d = wr_idx_q + IDX_W'(1);
               end
            end
         end
         ST_WAIT: begin
            if (lat_cnt_q == CNT_W'(1)) begin
               m_class_d = nn_class;
               m_valid_d = 1'b1;
               lat_cnt_d = '0;
               state_d   = ST_OUT;
            end else begin
               lat_cnt_d = lat_cnt_q - CNT_W'(1);
            end
         end
         ST_OUT: begin
            if (m_valid_q && m_ready) begin
               m_valid_d     = 1'b0;
               frame_valid_d = 1'b0;
               state_d       = ST_FILL;
            end
         end
         default: state_d = ST_FILL;
      endcase

      // Registered ready: low straight out of reset, rises one edge later
      s_ready_d = (state_d == ST_FILL);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_FILL;
         wr_idx_q       <= '0;
         lat_cnt_q      <= '0;
         frame_vector_q <= '0;
         s_ready_q      <= 1'b0;
         frame_valid_q  <= 1'b0;
         m_valid_q      <= 1'b0;
         m_class_q      <= '0;
         frame_err_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         wr_idx_q       <= wr_idx_d;
         lat_cnt_q      <= lat_cnt_d;
         frame_vector_q <= frame_vector_d;
         s_ready_q      <= s_ready_d;
         frame_valid_q  <= frame_valid_d;
         m_valid_q      <= m_valid_d;
         m_class_q      <= m_class_d;
         frame_err_q    <= frame_err_d;
      end
   end

   assign s_ready      = s_ready_q;
   assign frame_vector = frame_vector_q;
   assign frame_valid  = frame_valid_q;
   assign m_valid      = m_valid_q;
   assign m_class      = m_class_q;
   assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_nn_frame_loader.sv
// Bench for nn_frame_loader: directed frame scenarios with random data and gaps,
// checked against a word-count level reference model of frame assembly and latency.
module tb_nn_frame_loader;

   localparam int IN_SIZE    = 16;
   localparam int DATA_W     = 16;
   localparam int CLASS_W    = 2;
   localparam int NN_LATENCY = 6;

   logic                            clk = 1'b0;
   logic                            rst = 1'b0;
   logic [DATA_W-1:0]               s_data = '0;
   logic                            s_valid = 1'b0;
   logic                            s_last = 1'b0;
   logic                            s_ready;
   logic [IN_SIZE-1:0][DATA_W-1:0]  frame_vector;
   logic                            frame_valid;
   logic [CLASS_W-1:0]              nn_class = '0;
   logic [CLASS_W-1:0]              m_class;
   logic                            m_valid;
   logic                            m_ready = 1'b0;
   logic                            frame_err;

   nn_frame_loader #(
      .IN_SIZE(IN_SIZE), .DATA_W(DATA_W), .CLASS_W(CLASS_W), .NN_LATENCY(NN_LATENCY)
   ) dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready), .frame_vector(frame_vector), .frame_valid(frame_valid),
      .nn_class(nn_class), .m_class(m_class), .m_valid(m_valid), .m_ready(m_ready),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   int errors = 0;
   int checks = 0;

   // Reference model: expected vector contents and number of words of the frame in progress
   logic [DATA_W-1:0] model_vec [IN_SIZE];
   int                fill_cnt = 0;
   logic [CLASS_W-1:0] exp_cls;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < IN_SIZE; i++) model_vec[i] = '0;
      fill_cnt = 0;
   endtask

   task automatic check_vec(input string tag);
      for (int i = 0; i < IN_SIZE; i++)
         check($sformatf("%s[%0d]", tag, i), 64'(frame_vector[i]), 64'(model_vec[i]));
   endtask

   // code: 0 = stored mid-frame, 1 = frame complete, 2 = frame discarded
   task automatic put_word(input logic [DATA_W-1:0] d, input logic l, output int code,
                           output int t_acc);
      int guard = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      while (s_ready !== 1'b1 && guard < 50) begin
         tick();
         guard++;
      end
      if (guard >= 50) check("ready_timeout", 64'(s_ready), 64'd1);
      tick();
      t_acc   = cyc;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = DATA_W'($urandom);
      if (l && fill_cnt == IN_SIZE - 1) begin
         model_vec[fill_cnt] = d;
         fill_cnt = 0;
         code = 1;
      end else if (l || fill_cnt == IN_SIZE - 1) begin
         fill_cnt = 0;
         code = 2;
      end else begin
         model_vec[fill_cnt] = d;
         fill_cnt++;
         code = 0;
      end
   endtask

   task automatic send_frame(input int n, input int last_pos, input int gap_pct, input bit rnd,
                             output int t_last, output bit done);
      int code;
      int t;
      done   = 1'b0;
      t_last = 0;
      for (int i = 0; i < n; i++) begin
         while (int'($urandom_range(99)) < gap_pct) tick();
         put_word(rnd ? DATA_W'($urandom) : DATA_W'(i + 1), (i + 1) == last_pos, code, t);
         if (code == 2) begin
            check("frame_err_pulse", 64'(frame_err), 64'd1);
            check("s_ready_after_err", 64'(s_ready), 64'd1);
            check("m_valid_after_err", 64'(m_valid), 64'd0);
            tick();
            check("frame_err_clear", 64'(frame_err), 64'd0);
            check("m_valid_err_idle", 64'(m_valid), 64'd0);
         end else begin
            check("frame_err_quiet", 64'(frame_err), 64'd0);
            if (code == 1) begin
               done   = 1'b1;
               t_last = t;
               check("frame_valid_set", 64'(frame_valid), 64'd1);
               check("s_ready_drop", 64'(s_ready), 64'd0);
            end
         end
      end
   endtask

   task automatic wait_result(input int t_last, input bit vary, input logic [CLASS_W-1:0] cst,
                              input bit rdy_early);
      for (int k = 1; k <= NN_LATENCY; k++) begin
         nn_class = vary ? CLASS_W'($urandom) : cst;
         m_ready  = rdy_early && (k < NN_LATENCY);
         if (k == NN_LATENCY) exp_cls = nn_class;
         tick();
         if (k < NN_LATENCY) check("m_valid_early", 64'(m_valid), 64'd0);
         check("frame_valid_wait", 64'(frame_valid), 64'd1);
         check("s_ready_wait", 64'(s_ready), 64'd0);
      end
      nn_class = CLASS_W'($urandom);
      check("m_valid_rise", 64'(m_valid), 64'd1);
      check("m_class", 64'(m_class), 64'(exp_cls));
      check("latency", 64'(cyc - t_last), 64'(NN_LATENCY));
      check_vec("vec");
   endtask

   task automatic release_result(input int hold);
      for (int h = 0; h < hold; h++) begin
         m_ready  = 1'b0;
         s_valid  = 1'(h % 2);
         nn_class = CLASS_W'($urandom);
         tick();
         check("hold_m_valid", 64'(m_valid), 64'd1);
         check("hold_m_class", 64'(m_class), 64'(exp_cls));
         check("hold_s_ready", 64'(s_ready), 64'd0);
         check("hold_frame_valid", 64'(frame_valid), 64'd1);
         check_vec("hold_vec");
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      check("hs_m_valid", 64'(m_valid), 64'd0);
      check("hs_frame_valid", 64'(frame_valid), 64'd0);
      check("hs_s_ready", 64'(s_ready), 64'd1);
   endtask

   initial begin
      int  t_last;
      bit  done;

      model_reset();
      // Reset state
      #3;
      check("rst_s_ready", 64'(s_ready), 64'd0);
      check("rst_frame_valid", 64'(frame_valid), 64'd0);
      check("rst_m_valid", 64'(m_valid), 64'd0);
      check("rst_m_class", 64'(m_class), 64'd0);
      check("rst_frame_err", 64'(frame_err), 64'd0);
      check_vec("rst_vec");
      tick();
      tick();
      rst = 1'b1;
      check("rel_s_ready_low", 64'(s_ready), 64'd0);
      tick();
      check("rel_s_ready_high", 64'(s_ready), 64'd1);

      // Clean frame 1..16, constant class 2'b10
      send_frame(IN_SIZE, IN_SIZE, 0, 1'b0, t_last, done);
      check("t1_done", 64'(done), 64'd1);
      wait_result(t_last, 1'b0, 2'b10, 1'b0);
      release_result(0);

      // Early s_last on word 7, then a clean random frame
      send_frame(7, 7, 0, 1'b1, t_last, done);
      check("t2_discard", 64'(done), 64'd0);
      send_frame(IN_SIZE, IN_SIZE, 0, 1'b1, t_last, done);
      wait_result(t_last, 1'b1, 2'b00, 1'b0);
      release_result(0);

      // 16 words without s_last, then a clean frame starting from slot 0
      send_frame(IN_SIZE, 0, 0, 1'b1, t_last, done);
      check("t3_discard", 64'(done), 64'd0);
      send_frame(IN_SIZE, IN_SIZE, 0, 1'b1, t_last, done);
      wait_result(t_last, 1'b1, 2'b00, 1'b0);

      // Downstream back-pressure for 10 cycles
      release_result(10);

      // 50% input gaps, early m_ready during WAIT is ignored
      send_frame(IN_SIZE, IN_SIZE, 50, 1'b0, t_last, done);
      check("t5_done", 64'(done), 64'd1);
      wait_result(t_last, 1'b1, 2'b00, 1'b1);
      release_result(2);

      // Reset while the latency counter sits at 3
      send_frame(IN_SIZE, IN_SIZE, 0, 1'b1, t_last, done);
      repeat (NN_LATENCY - 3) tick();
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check("r6_s_ready", 64'(s_ready), 64'd0);
      check("r6_frame_valid", 64'(frame_valid), 64'd0);
      check("r6_m_valid", 64'(m_valid), 64'd0);
      check("r6_m_class", 64'(m_class), 64'd0);
      check("r6_frame_err", 64'(frame_err), 64'd0);
      check_vec("r6_vec");
      tick();
      tick();
      rst = 1'b1;
      check("r6_rel_s_ready_low", 64'(s_ready), 64'd0);
      tick();
      check("r6_rel_s_ready_high", 64'(s_ready), 64'd1);
      for (int k = 0; k < NN_LATENCY + 2; k++) begin
         tick();
         check("r6_no_stale", 64'(m_valid), 64'd0);
      end
      send_frame(IN_SIZE, IN_SIZE, 25, 1'b1, t_last, done);
      check("r6_done", 64'(done), 64'd1);
      wait_result(t_last, 1'b1, 2'b00, 1'b0);
      release_result(1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
